// File: rtl/spi_flash_reader.sv
// SPI mode-0 flash read initiator: sends READ_CMD plus a 24-bit address, then streams
// the returned bytes out through a one-entry output register on a valid/ready handshake.
module spi_flash_reader #(
  parameter logic [7:0] READ_CMD       = 8'h03,
  parameter int         CS_HIGH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] address,
  input  logic [15:0] length,
  output logic        busy,
  output logic [7:0]  data,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        flash_csn,
  output logic        flash_sck,
  output logic        flash_mosi,
  input  logic        flash_miso
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(CS_HIGH_CYCLES - 1);

  state_t      state, state_nxt;
  logic        ph;
  logic [4:0]  bit_cnt;
  logic [31:0] tx_sr;
  logic [15:0] bytes_left;
  logic [7:0]  rx_sr;
  logic        rx_full;
  logic [3:0]  gap_cnt;

  logic        out_free;
  logic [7:0]  rx_byte;
  logic        shifting;
  logic        byte_done;
  logic        load_rx;
  logic        load_out;

  assign out_free = !data_valid || data_ready;
  assign rx_byte  = {rx_sr[6:0], flash_miso};

  // ph is only ever set in CMD/ADDR/DATA, so it doubles as the serial clock.
  assign busy       = (state != IDLE);
  assign flash_csn  = !((state == CMD) || (state == ADDR) || (state == DATA));
  assign flash_sck  = ph;
  assign flash_mosi = ((state == CMD) || (state == ADDR)) && tx_sr[31];

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shifting  = 1'b0;
    byte_done = 1'b0;
    load_rx   = 1'b0;
    case (state)
      IDLE: if (start && length != 16'd0) state_nxt = CMD;
      CMD:  if (ph && bit_cnt == 5'd7)    state_nxt = ADDR;
      ADDR: if (ph && bit_cnt == 5'd23)   state_nxt = DATA;
      DATA: begin
        // A completed byte parked in rx_sr freezes sck low until the output register frees.
        if (rx_full) begin
          load_rx = out_free;
        end else if (bytes_left == 16'd0) begin
          state_nxt = GAP;
        end else begin
          shifting  = 1'b1;
          byte_done = ph && (bit_cnt == 5'd7);
        end
      end
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    load_out = load_rx || (byte_done && out_free);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ph         <= 1'b0;
      bit_cnt    <= 5'd0;
      tx_sr      <= 32'd0;
      bytes_left <= 16'd0;
      rx_sr      <= 8'd0;
      rx_full    <= 1'b0;
      gap_cnt    <= 4'd0;
      data       <= 8'd0;
      data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ph      <= 1'b0;
          bit_cnt <= 5'd0;
          if (start && length != 16'd0) begin
            tx_sr      <= {READ_CMD, address};
            bytes_left <= length;
          end
        end
        CMD, ADDR: begin
          ph <= ~ph;
          if (ph) begin
            tx_sr   <= {tx_sr[30:0], 1'b0};
            bit_cnt <= (state_nxt != state) ? 5'd0 : bit_cnt + 5'd1;
          end
        end
        DATA: begin
          if (shifting) begin
            ph <= ~ph;
            if (ph) begin
              rx_sr   <= rx_byte;
              bit_cnt <= byte_done ? 5'd0 : bit_cnt + 5'd1;
              if (byte_done) begin
                bytes_left <= bytes_left - 16'd1;
                rx_full    <= !out_free;
              end
            end
          end else if (load_rx) begin
            rx_full <= 1'b0;
          end
        end
        default: ph <= 1'b0;
      endcase

      gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;

      if (load_out) begin
        data       <= rx_full ? rx_sr : rx_byte;
        data_valid <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Synthesizable single-lane SPI flash read initiator, SPI mode 0.
- Given a 24-bit start address and a byte count, it issues a READ command (0x03) plus address, then streams the returned bytes out on a valid/ready interface.
- Sits between the CPU-side bootloader or DMA logic and the board flash pins; it is the initiator end of the link modelled by sim_spiflash.

Parameters:
- READ_CMD, 8'h03: command byte sent first, MSB first.
- CS_HIGH_CYCLES, 4: minimum clk cycles flash_csn is held high after a transfer before busy drops (range 1..15).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; accepted only when busy=0.
- address  input  24  flash byte address; sampled on the accepted start.
- length  input  16  bytes to read; sampled on the accepted start.
- busy  output  1  high from the accepted start until the CS high-time completes.
- data  output  8  read byte, MSB was first on the wire.
- data_valid  output  1  data holds a byte.
- data_ready  input  1  consumer accepts data when valid&&ready.
- flash_csn  output  1  chip select, active low.
- flash_sck  output  1  serial clock; idles low.
- flash_mosi  output  1  serial data to flash.
- flash_miso  input  1  serial data from flash.

Behaviour:
- Reset (reset_n=0 at a clk edge), effective the next cycle, including mid-transfer: busy=0, data_valid=0, data=0, flash_csn=1, flash_sck=0, flash_mosi=0, counters cleared.
- No partial byte is ever emitted after reset.
- States:
  - IDLE: start && length!=0 -> latch address/length, CMD; flash_csn=0 on the next cycle.
  - start with length==0 is ignored: busy stays 0.
  - CMD: 8 bits of READ_CMD.
  - ADDR: 24 bits, address[23] first.
  - DATA: length bytes.
  - GAP: flash_csn=1, count CS_HIGH_CYCLES, then IDLE.
- Bit timing: one bit spans 2 clk cycles.
  - Phase L: sck=0, mosi driven with the current bit.
  - Phase H: sck=1.
  - MISO is sampled at the clk edge ending phase H, i.e. the falling sck edge.
  - The first phase L coincides with the first csn=0 cycle.
- Command plus address is 32 bits, 64 cycles. The first data bit's phase L immediately follows the last address bit's phase H.
- mosi=0 throughout DATA.
- Byte output and stall:
  - After the 8th bit of a byte is sampled, the byte moves to the output register with data_valid=1 on the next cycle, if the register is empty or is being consumed that cycle.
  - Otherwise the byte waits in the shift register with sck held low (legal stall in mode 0) until the register frees.
  - The next byte shifts while the previous one waits: single-entry output buffer plus shift register.
- data and data_valid are stable while valid&&!ready.
- Unloaded throughput: 1 byte per 16 clk.
- End of transfer:
  - After the final byte is sampled, the last sck high→low edge happens, then csn rises on the next cycle (GAP entry).
  - The final byte may still be pending in the output register during GAP/IDLE.
  - busy drops independently of data_valid.
- A start while busy=1 is ignored.
- A start while busy=0 but data_valid=1 is accepted; the output register still drains in order.
- length wraps nothing; the address auto-increment is the flash's responsibility, including wrap at 24 bits.
- First byte latency from the accepted start cycle: csn low at +1; first data_valid at +1+64+16 = cycle +81, with ready held high.

Test Plan:
- Reset idle: hold reset_n=0 3 cycles -> csn=1, sck=0, busy=0, data_valid=0; release -> outputs unchanged.
- Basic read against sim_spiflash preloaded with 0xA5,0x3C,0x7E,0x01 at 0x000100, start address=0x000100 length=4 ready=1:
  - MOSI carries 0x03,0x00,0x01,0x00.
  - Bytes A5,3C,7E,01 appear, first at start+81, then every 16 cycles.
  - csn rises after the last byte; busy falls 4 cycles later.
- Back-pressure: same read with data_ready=0 for 100 cycles after the first valid:
  - data stays 0xA5.
  - sck frozen low after the second byte completes.
  - Release -> 3C,7E,01 delivered in order, no duplicate or loss.
- length=0 start -> busy never asserts, csn stays 1. A start while busy -> ignored, count of delivered bytes unchanged.
- Reset mid-DATA (after byte 2 of length=8) -> next cycle csn=1, sck=0, data_valid=0. A new read of length=2 at 0x000102 returns 7E,01.
- Address wrap: flash image with 0x11 at 0xFFFFFF, 0x22 at 0x000000; read at 0xFFFFFF length=2 -> 11,22.
